// File: rtl/swing_duration_meter_if.sv
// Result handshake bundle between swing_duration_meter and the game logic.
// master = the meter (drives the result), slave = the consumer (drives swing/ack).
interface swing_duration_meter_if;
  logic       swing;
  logic       ack;
  logic [4:0] duration;
  logic       valid;
  logic       busy;
  logic       overflow;

  modport master (
    input  swing,
    input  ack,
    output duration,
    output valid,
    output busy,
    output overflow
  );

  modport slave (
    output swing,
    output ack,
    input  duration,
    input  valid,
    input  busy,
    input  overflow
  );
endinterface

// File: rtl/swing_duration_meter.sv
// Times a debounced swing/button hold in half-second units and hands the result over with valid/ack.
// Optional macro SWING_ROUND_HALF_EN: round the captured duration to the nearest unit instead of flooring.
module swing_duration_meter #(
  parameter int HALF_SEC_CYCLES = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MAX_UNITS       = 31
) (
  input logic                    CLOCK_50,
  input logic                    KEY,
  swing_duration_meter_if.master bus
);

  localparam int SUB_W = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(HALF_SEC_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       UNITS_MAX = 5'(MAX_UNITS);

  typedef enum logic [1:0] {
    IDLE,
    TIMING,
    HOLD
  } state_t;

  // Input path: synchronizer, debouncer, edge detect
  logic             sync1, sync2;
  logic             deb_level, deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             rise, fall;

  // NOTE: KEY is sampled on the clock edge like any other input, so it must be
  // held across at least one rising edge of CLOCK_50 to clear the block.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values;
      // blocking ones here would collapse the two synchronizer stages into one.
      sync1    <= bus.swing;
      sync2    <= sync1;
      deb_prev <= deb_level;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign rise = deb_level & ~deb_prev;
  assign fall = ~deb_level & deb_prev;

  // Measurement state
  state_t           state, state_n;
  logic [SUB_W-1:0] sub_cnt, sub_cnt_n;
  logic [4:0]       units, units_n;
  logic [4:0]       duration_q, duration_n;
  logic             valid_q, valid_n;
  logic             busy_q, busy_n;
  logic             ovf_q, ovf_n;

  // One TIMING step viewed post-increment, so a wrap coinciding with the fall is counted.
  logic             wrap;
  logic [SUB_W-1:0] sub_inc;
  logic [4:0]       units_inc;
  logic             ovf_inc;
  logic [4:0]       dur_cap;
  logic             ovf_cap;

  always_comb begin
    wrap      = (sub_cnt == SUB_LAST);
    sub_inc   = wrap ? '0 : sub_cnt + SUB_W'(1);
    units_inc = units;
    ovf_inc   = ovf_q;
    if (wrap) begin
      if (units == UNITS_MAX) ovf_inc = 1'b1;
      else                    units_inc = units + 5'd1;
    end

    dur_cap = units_inc;
    ovf_cap = ovf_inc;
`ifdef SWING_ROUND_HALF_EN
    if (sub_inc >= SUB_W'(HALF_SEC_CYCLES / 2)) begin
      if (units_inc == UNITS_MAX) ovf_cap = 1'b1;
      else                        dur_cap = units_inc + 5'd1;
    end
`endif
  end

  // NOTE: every variable gets its hold value first; a path that left one
  // unassigned would make synthesis infer a latch to remember it.
  always_comb begin
    state_n    = state;
    sub_cnt_n  = sub_cnt;
    units_n    = units;
    duration_n = duration_q;
    valid_n    = valid_q;
    busy_n     = busy_q;
    ovf_n      = ovf_q;

    case (state)
      IDLE: begin
        if (rise) begin
          state_n   = TIMING;
          sub_cnt_n = '0;
          units_n   = '0;
          ovf_n     = 1'b0;
          busy_n    = 1'b1;
        end
      end

      TIMING: begin
        sub_cnt_n = sub_inc;
        units_n   = units_inc;
        ovf_n     = ovf_inc;
        if (fall) begin
          duration_n = dur_cap;
          ovf_n      = ovf_cap;
          valid_n    = 1'b1;
          busy_n     = 1'b0;
          state_n    = HOLD;
        end
      end

      HOLD: begin
        // Edges seen here are dropped; a still-high swing needs a fresh rise later.
        if (bus.ack) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      state      <= IDLE;
      sub_cnt    <= '0;
      units      <= '0;
      duration_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_n;
      sub_cnt    <= sub_cnt_n;
      units      <= units_n;
      duration_q <= duration_n;
      valid_q    <= valid_n;
      busy_q     <= busy_n;
      ovf_q      <= ovf_n;
    end
  end

  assign bus.duration = duration_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_swing_duration_meter.sv
// Directed bench for swing_duration_meter with short timing constants (10-cycle unit, 3-cycle debounce).
module tb_swing_duration_meter;

  logic CLOCK_50;
  logic KEY;
  int   n_checks;
  int   n_fail;

  swing_duration_meter_if bus();

  swing_duration_meter #(
    .HALF_SEC_CYCLES(10),
    .DEBOUNCE_CYCLES(3),
    .MAX_UNITS      (31)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .KEY     (KEY),
    .bus     (bus)
  );

`ifdef SWING_ROUND_HALF_EN
  localparam logic [4:0] EXP_35 = 5'd4;
  localparam logic [4:0] EXP_15 = 5'd2;
`else
  localparam logic [4:0] EXP_35 = 5'd3;
  localparam logic [4:0] EXP_15 = 5'd1;
`endif

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] dur, input logic vld,
                            input logic bsy, input logic ovf);
    check({tag, "_duration"}, bus.duration, dur);
    check({tag, "_valid"},    bus.valid,    vld);
    check({tag, "_busy"},     bus.busy,     bsy);
    check({tag, "_overflow"}, bus.overflow, ovf);
  endtask

  task automatic pulse(input int len);
    bus.swing = 1'b1;
    repeat (len) tick();
    bus.swing = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.valid === 1'b1) break;
      tick();
    end
    check({tag, "_valid_seen"}, bus.valid, 1'b1);
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  // Watch for any busy/valid activity over a window; returns 1 if any was seen.
  task automatic watch_quiet(input int cycles, output logic seen);
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) seen = 1'b1;
    end
  endtask

  logic seen;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    KEY       = 1'b1;
    bus.swing = 1'b0;
    bus.ack   = 1'b0;

    // 1: reset held two cycles while swing toggles
    tick();
    check_outs("rst_c1", 5'd0, 1'b0, 1'b0, 1'b0);
    bus.swing = 1'b1;
    tick();
    check_outs("rst_c2", 5'd0, 1'b0, 1'b0, 1'b0);
    bus.swing = 1'b0;
    KEY       = 1'b0;
    tick();
    check_outs("rst_rel", 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();

    // 2: 35-cycle swing, result held until ack
    bus.swing = 1'b1;
    repeat (20) tick();
    check("s2_busy_mid", bus.busy, 1'b1);
    check("s2_valid_mid", bus.valid, 1'b0);
    repeat (15) tick();
    bus.swing = 1'b0;
    wait_valid("s2", 20);
    check_outs("s2_cap", EXP_35, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    check_outs("s2_hold", EXP_35, 1'b1, 1'b0, 1'b0);
    do_ack();
    check_outs("s2_ack", EXP_35, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();

    // 3: exact 30 cycles (wrap and fall together), then a 2-cycle glitch
    pulse(30);
    wait_valid("s3", 20);
    check_outs("s3_cap", 5'd3, 1'b1, 1'b0, 1'b0);
    do_ack();
    repeat (5) tick();
    bus.swing = 1'b1;
    tick();
    tick();
    bus.swing = 1'b0;
    watch_quiet(15, seen);
    check("s3_glitch_quiet", seen, 1'b0);

    // 4: saturation and overflow, then a short swing clears overflow
    pulse(400);
    wait_valid("s4", 20);
    check_outs("s4_cap", 5'd31, 1'b1, 1'b0, 1'b1);
    do_ack();
    check("s4_ovf_sticky", bus.overflow, 1'b1);
    repeat (5) tick();
    pulse(15);
    wait_valid("s4b", 20);
    check_outs("s4b_cap", EXP_15, 1'b1, 1'b0, 1'b0);
    do_ack();
    repeat (5) tick();

    // 5: second swing during HOLD is ignored and not queued
    pulse(12);
    wait_valid("s5", 20);
    check_outs("s5_cap", 5'd1, 1'b1, 1'b0, 1'b0);
    pulse(20);
    repeat (10) tick();
    check_outs("s5_hold", 5'd1, 1'b1, 1'b0, 1'b0);
    do_ack();
    check_outs("s5_ack", 5'd1, 1'b0, 1'b0, 1'b0);
    watch_quiet(30, seen);
    check("s5_no_second", seen, 1'b0);

    // 6: reset mid-TIMING abandons the measurement
    bus.swing = 1'b1;
    repeat (18) tick();
    check("s6_busy_mid", bus.busy, 1'b1);
    KEY = 1'b1;
    tick();
    KEY       = 1'b0;
    bus.swing = 1'b0;
    check_outs("s6_rst", 5'd0, 1'b0, 1'b0, 1'b0);
    watch_quiet(20, seen);
    check("s6_no_valid", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
